// File: rtl/psg_multi.sv
// Multi-voice programmable sound generator: CHANNELS tone voices, shared 17-bit noise LFSR, shared envelope.
// Optional macro PSG_STEREO_EN adds per-voice pan bits (control [3:2]) and MIX_L / MIX_R outputs.
module psg_multi #(
    parameter int CHANNELS = 3,
    parameter int TONE_W   = 12,
    parameter int PRESCALE = 8,
    parameter int MIX_W    = 8 + $clog2(CHANNELS + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CE,
    input  logic                    WE,
    input  logic [7:0]              ADDR,
    input  logic [7:0]              DI,
    output logic [7:0]              DO,
    output logic [8*CHANNELS-1:0]   LEVEL,
    output logic [MIX_W-1:0]        MIX
`ifdef PSG_STEREO_EN
    ,
    output logic [MIX_W-1:0]        MIX_L,
    output logic [MIX_W-1:0]        MIX_R
`endif
);

    localparam int HI_W = TONE_W - 8;
`ifdef PSG_STEREO_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h3;
`endif

    localparam logic [7:0] YM_TABLE [32] = '{
        8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
        8'h06, 8'h07, 8'h09, 8'h0A, 8'h0C, 8'h0E, 8'h11, 8'h13,
        8'h17, 8'h1B, 8'h20, 8'h25, 8'h2C, 8'h35, 8'h3E, 8'h47,
        8'h54, 8'h66, 8'h77, 8'h88, 8'hA1, 8'hC0, 8'hE0, 8'hFF
    };

    logic [7:0]      per_lo_reg [CHANNELS];
    logic [HI_W-1:0] per_hi_reg [CHANNELS];
    logic [4:0]      vol_reg    [CHANNELS];
    logic [3:0]      ctrl_reg   [CHANNELS];
    logic [4:0]      noise_per_reg;
    logic [7:0]      env_per_lo_reg;
    logic [7:0]      env_per_hi_reg;
    logic [3:0]      shape_reg;
    logic            env_restart_reg;

    // A shape write leaves a restart pending until the next CE edge; later writes just re-arm it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < CHANNELS; c++) begin
                per_lo_reg[c] <= '0;
                per_hi_reg[c] <= '0;
                vol_reg[c]    <= '0;
                ctrl_reg[c]   <= '0;
            end
            noise_per_reg   <= '0;
            env_per_lo_reg  <= '0;
            env_per_hi_reg  <= '0;
            shape_reg       <= '0;
            env_restart_reg <= 1'b0;
        end else begin
            if (CE)
                env_restart_reg <= 1'b0;
            if (WE) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ADDR[7:2] == 6'(c)) begin
                        case (ADDR[1:0])
                            2'd0:    per_lo_reg[c] <= DI;
                            2'd1:    per_hi_reg[c] <= DI[HI_W-1:0];
                            2'd2:    vol_reg[c]    <= DI[4:0];
                            default: ctrl_reg[c]   <= DI[3:0] & CTRL_MASK;
                        endcase
                    end
                end
                case (ADDR)
                    8'hF0: noise_per_reg  <= DI[4:0];
                    8'hF1: env_per_lo_reg <= DI;
                    8'hF2: env_per_hi_reg <= DI;
                    8'hF3: begin
                        shape_reg       <= DI[3:0];
                        env_restart_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        DO = 8'h00;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ADDR[7:2] == 6'(c)) begin
                case (ADDR[1:0])
                    2'd0:    DO = per_lo_reg[c];
                    2'd1:    DO = 8'(per_hi_reg[c]);
                    2'd2:    DO = {3'b000, vol_reg[c]};
                    default: DO = {4'b0000, ctrl_reg[c]};
                endcase
            end
        end
        case (ADDR)
            8'hF0:   DO = {3'b000, noise_per_reg};
            8'hF1:   DO = env_per_lo_reg;
            8'hF2:   DO = env_per_hi_reg;
            8'hF3:   DO = {4'b0000, shape_reg};
            default: ;
        endcase
    end

    logic [4:0] pre_cnt_reg;
    logic       noise_div_reg;
    logic       tick;
    logic       noise_tick;

    assign tick       = CE && (pre_cnt_reg == 5'(PRESCALE - 1));
    assign noise_tick = tick && noise_div_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_cnt_reg   <= '0;
            noise_div_reg <= 1'b0;
        end else if (CE) begin
            pre_cnt_reg <= tick ? 5'd0 : pre_cnt_reg + 5'd1;
            if (tick)
                noise_div_reg <= ~noise_div_reg;
        end
    end

    logic [4:0]  noise_cnt_reg;
    logic [16:0] lfsr_reg;
    logic        noise_out;

    assign noise_out = (noise_per_reg != 5'd0) && lfsr_reg[0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            noise_cnt_reg <= '0;
            lfsr_reg      <= 17'h00001;
        end else if (noise_tick) begin
            if (noise_per_reg == 5'd0) begin
                noise_cnt_reg <= '0;
            end else if (noise_cnt_reg >= noise_per_reg - 5'd1) begin
                noise_cnt_reg <= '0;
                lfsr_reg      <= {lfsr_reg[0] ^ lfsr_reg[3], lfsr_reg[16:1]};
            end else begin
                noise_cnt_reg <= noise_cnt_reg + 5'd1;
            end
        end
    end

    logic [15:0] env_per;
    logic [15:0] env_limit;
    logic [15:0] env_cnt_reg;
    logic [4:0]  env_level_reg;
    logic        env_up_reg;
    logic        env_hold_reg;
    logic        env_at_end;

    assign env_per    = {env_per_hi_reg, env_per_lo_reg};
    assign env_limit  = (env_per == 16'd0) ? 16'd0 : env_per - 16'd1;
    assign env_at_end = env_up_reg ? (env_level_reg == 5'd31) : (env_level_reg == 5'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            env_cnt_reg   <= '0;
            env_level_reg <= '0;
            env_up_reg    <= 1'b0;
            env_hold_reg  <= 1'b1;
        end else if (CE) begin
            if (env_restart_reg) begin
                env_level_reg <= shape_reg[2] ? 5'd0 : 5'd31;
                env_up_reg    <= shape_reg[2];
                env_cnt_reg   <= '0;
                env_hold_reg  <= 1'b0;
            end else if (tick) begin
                if (env_cnt_reg >= env_limit) begin
                    env_cnt_reg <= '0;
                    if (!env_hold_reg) begin
                        if (!env_at_end) begin
                            env_level_reg <= env_up_reg ? env_level_reg + 5'd1 : env_level_reg - 5'd1;
                        end else if (!shape_reg[3]) begin
                            env_level_reg <= 5'd0;
                            env_hold_reg  <= 1'b1;
                        end else if (shape_reg[0]) begin
                            env_level_reg <= shape_reg[1] ? ~env_level_reg : env_level_reg;
                            env_hold_reg  <= 1'b1;
                        end else if (shape_reg[1]) begin
                            env_up_reg <= ~env_up_reg;
                        end else begin
                            env_level_reg <= env_up_reg ? 5'd0 : 5'd31;
                        end
                    end
                end else begin
                    env_cnt_reg <= env_cnt_reg + 16'd1;
                end
            end
        end
    end

    logic [8*CHANNELS-1:0] level_next;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_voice
        logic [TONE_W-1:0] cnt_reg;
        logic [TONE_W-1:0] period;
        logic              tone_reg;
        logic              gate;
        logic [4:0]        amp;
        logic [7:0]        level_reg;

        assign period = {per_hi_reg[gi], per_lo_reg[gi]};

        // Compare uses >= so a period shortened below the running count expires on the next tick.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                cnt_reg  <= '0;
                tone_reg <= 1'b0;
            end else if (tick) begin
                if (period == '0) begin
                    cnt_reg  <= '0;
                    tone_reg <= 1'b0;
                end else if (cnt_reg >= period - TONE_W'(1)) begin
                    cnt_reg  <= '0;
                    tone_reg <= ~tone_reg;
                end else begin
                    cnt_reg <= cnt_reg + TONE_W'(1);
                end
            end
        end

        assign gate = (~ctrl_reg[gi][0] | tone_reg) & (~ctrl_reg[gi][1] | noise_out);
        assign amp  = !gate ? 5'd0 :
                      vol_reg[gi][4] ? env_level_reg : {vol_reg[gi][3:0], vol_reg[gi][3]};
        assign level_next[8*gi +: 8] = YM_TABLE[amp];

        always_ff @(posedge CLK) begin
            if (RESET)
                level_reg <= '0;
            else if (CE)
                level_reg <= level_next[8*gi +: 8];
        end

        assign LEVEL[8*gi +: 8] = level_reg;
    end

    logic [MIX_W-1:0] mix_next;
    logic [MIX_W-1:0] mix_reg;

    always_comb begin
        mix_next = '0;
        for (int c = 0; c < CHANNELS; c++)
            mix_next = mix_next + MIX_W'(level_next[8*c +: 8]);
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            mix_reg <= '0;
        else if (CE)
            mix_reg <= mix_next;
    end

    assign MIX = mix_reg;

`ifdef PSG_STEREO_EN
    logic [MIX_W-1:0] mix_l_next;
    logic [MIX_W-1:0] mix_r_next;
    logic [MIX_W-1:0] mix_l_reg;
    logic [MIX_W-1:0] mix_r_reg;

    always_comb begin
        mix_l_next = '0;
        mix_r_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ctrl_reg[c][2])
                mix_l_next = mix_l_next + MIX_W'(level_next[8*c +: 8]);
            if (ctrl_reg[c][3])
                mix_r_next = mix_r_next + MIX_W'(level_next[8*c +: 8]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mix_l_reg <= '0;
            mix_r_reg <= '0;
        end else if (CE) begin
            mix_l_reg <= mix_l_next;
            mix_r_reg <= mix_r_next;
        end
    end

    assign MIX_L = mix_l_reg;
    assign MIX_R = mix_r_reg;
`endif

endmodule

// File: tb/tb_psg_multi.sv
// Self-checking bench for psg_multi: register vectors, directed timing sequences and randomized
// runs compared against a closed-form behavioural model of tone, noise and envelope.
module tb_psg_multi;

    localparam int CH    = 3;
    localparam int MIX_W = 10;

    logic              CLK = 1'b0;
    logic              RESET, CE, WE;
    logic [7:0]        ADDR, DI;
    logic [7:0]        DO;
    logic [8*CH-1:0]   LEVEL;
    logic [MIX_W-1:0]  MIX;
`ifdef PSG_STEREO_EN
    logic [MIX_W-1:0]  MIX_L, MIX_R;
`endif

    always #5 CLK = ~CLK;

    psg_multi #(.CHANNELS(CH), .TONE_W(12), .PRESCALE(8)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .WE(WE), .ADDR(ADDR), .DI(DI),
        .DO(DO), .LEVEL(LEVEL), .MIX(MIX)
`ifdef PSG_STEREO_EN
        , .MIX_L(MIX_L), .MIX_R(MIX_R)
`endif
    );

    localparam logic [7:0] YM [32] = '{
        8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
        8'h06, 8'h07, 8'h09, 8'h0A, 8'h0C, 8'h0E, 8'h11, 8'h13,
        8'h17, 8'h1B, 8'h20, 8'h25, 8'h2C, 8'h35, 8'h3E, 8'h47,
        8'h54, 8'h66, 8'h77, 8'h88, 8'hA1, 8'hC0, 8'hE0, 8'hFF
    };

    int checks   = 0;
    int failures = 0;

    int cfg_per [CH];
    int cfg_vol [CH];
    int cfg_ctl [CH];
    int cfg_np, cfg_ep, cfg_shape;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic ce);
        CE = ce;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        WE = 1'b0;
        RESET = 1'b1;
        step(1'b0);
        step(1'b0);
        RESET = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ADDR = a;
        DI = d;
        WE = 1'b1;
        step(1'b0);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        ADDR = a;
        #1;
        d = DO;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b1);
    endtask

    function automatic int lfsr_after(input int e);
        int v = 1;
        for (int i = 0; i < e; i++)
            v = (v >> 1) | (((v ^ (v >> 3)) & 1) << 16);
        return v;
    endfunction

    // Envelope level after s steps since a restart, from the ramp number and position.
    function automatic int env_model(input int shape, input int s);
        int cont = (shape >> 3) & 1;
        int att  = (shape >> 2) & 1;
        int alt  = (shape >> 1) & 1;
        int hold = shape & 1;
        int r    = s / 32;
        int pos  = s % 32;
        int fin, up;
        if (s < 32) return att ? s : 31 - s;
        if (!cont) return 0;
        if (hold) begin
            fin = att ? 31 : 0;
            return alt ? 31 - fin : fin;
        end
        up = alt ? (att ^ (r % 2)) : att;
        return up ? pos : 31 - pos;
    endfunction

    // LEVEL seen after k CE edges shows the state reached after k-1 CE edges.
    function automatic int exp_level(input int c, input int k);
        int m, t, tone, noise, env, amp, ep, v;
        if (k == 0) return 0;
        m = k - 1;
        t = m / 8;
        tone  = (cfg_per[c] == 0) ? 0 : (t / cfg_per[c]) % 2;
        noise = (cfg_np == 0) ? 0 : lfsr_after((t / 2) / cfg_np) & 1;
        ep    = (cfg_ep == 0) ? 1 : cfg_ep;
        env   = (m == 0) ? 0 : env_model(cfg_shape, t / ep);
        v     = cfg_vol[c];
        if (((cfg_ctl[c] & 1) == 0 || tone == 1) && ((cfg_ctl[c] & 2) == 0 || noise == 1))
            amp = (v & 16) ? env : (((v & 15) << 1) | ((v >> 3) & 1));
        else
            amp = 0;
        return int'(YM[amp]);
    endfunction

    initial begin
        logic [7:0] d;
        logic [8*CH-1:0] exp_lv;
        int exp_mix, k, lv;

        RESET = 1'b1; CE = 1'b0; WE = 1'b0; ADDR = 8'h00; DI = 8'h00;
        do_reset();

        for (int a = 0; a < 256; a++) begin
            rd(8'(a), d);
            check($sformatf("reset_read_%02h", a), d, 8'h00);
        end
        check("reset_level", LEVEL, '0);
        check("reset_mix", MIX, '0);
        $display("reset: 256 register reads and outputs checked");

        vecs[0]  = '{8'h00, 8'hA5, 8'hA5};
        vecs[1]  = '{8'h01, 8'hFF, 8'h0F};
        vecs[2]  = '{8'h06, 8'hFF, 8'h1F};
`ifdef PSG_STEREO_EN
        vecs[3]  = '{8'h0B, 8'hFF, 8'h0F};
`else
        vecs[3]  = '{8'h0B, 8'hFF, 8'h03};
`endif
        vecs[4]  = '{8'hF0, 8'hFF, 8'h1F};
        vecs[5]  = '{8'hF1, 8'h3C, 8'h3C};
        vecs[6]  = '{8'hF2, 8'hC3, 8'hC3};
        vecs[7]  = '{8'hF3, 8'hFF, 8'h0F};
        vecs[8]  = '{8'h0C, 8'h55, 8'h00};
        vecs[9]  = '{8'hF4, 8'h77, 8'h00};
        vecs[10] = '{8'hEF, 8'h99, 8'h00};
        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            check($sformatf("regvec_%0d_addr_%02h", i, vecs[i].addr), d, vecs[i].rdata);
            $display("vector %0d: addr=%02h wrote=%02h read=%02h", i, vecs[i].addr, vecs[i].wdata, d);
        end

        RESET = 1'b1; ADDR = 8'hF1; DI = 8'h5A; WE = 1'b1;
        step(1'b0);
        WE = 1'b0; RESET = 1'b0;
        rd(8'hF1, d);
        check("write_during_reset", d, 8'h00);
        $display("write during reset: read back %02h", d);

        do_reset();
        wr(8'h00, 8'd4); wr(8'h02, 8'h0F); wr(8'h03, 8'h01);
        run(32); check("tone_rate_k32", LEVEL[7:0], 8'h00);
        run(1);  check("tone_rate_k33", LEVEL[7:0], 8'hFF);
        check("tone_rate_mix_k33", MIX, 10'h0FF);
        run(31); check("tone_rate_k64", LEVEL[7:0], 8'hFF);
        run(1);  check("tone_rate_k65", LEVEL[7:0], 8'h00);
        $display("tone rate sequence: period 4 toggles every 32 CE");

        do_reset();
        wr(8'h06, 8'h10); wr(8'hF1, 8'h01); wr(8'hF3, 8'h0E);
        run(41);  check("env_e_up_step5", LEVEL[15:8], 8'h03);
        run(280); check("env_e_down_level23", LEVEL[15:8], 8'h47);
        wr(8'hF3, 8'h0E);
        run(1);   check("env_e_restart_edge", LEVEL[15:8], 8'h47);
        run(1);   check("env_e_after_restart", LEVEL[15:8], 8'h00);
        $display("envelope shape E: triangle and mid-ramp restart");

        do_reset();
        wr(8'h06, 8'h10); wr(8'hF1, 8'h01); wr(8'hF3, 8'h0B);
        run(249); check("env_b_ramp_end", LEVEL[15:8], 8'h00);
        run(8);   check("env_b_hold", LEVEL[15:8], 8'hFF);
        run(400); check("env_b_hold_late", LEVEL[15:8], 8'hFF);
        $display("envelope shape B: down ramp then hold high");

        do_reset();
        wr(8'h02, 8'h0F); wr(8'h06, 8'h0F); wr(8'h0A, 8'h0F);
`ifdef PSG_STEREO_EN
        wr(8'h0B, 8'h04);
`endif
        run(1);
        check("mix_dc_all", MIX, 10'h2FD);
        check("mix_dc_levels", LEVEL, 24'hFFFFFF);
`ifdef PSG_STEREO_EN
        check("mix_left", MIX_L, 10'h0FF);
        check("mix_right", MIX_R, 10'h000);
`endif
        $display("mix: three DC voices, MIX=%03h", MIX);

        do_reset();
        wr(8'h02, 8'h0F); wr(8'h03, 8'h01);
        run(100); check("tone_period_zero", LEVEL[7:0], 8'h00);
        $display("zero tone period with tone enabled");

        do_reset();
        wr(8'h00, 8'd12); wr(8'h02, 8'h0F); wr(8'h03, 8'h01);
        run(80); check("midcount_before", LEVEL[7:0], 8'h00);
        wr(8'h00, 8'd5);
        run(8);  check("midcount_tick_edge", LEVEL[7:0], 8'h00);
        run(1);  check("midcount_toggled", LEVEL[7:0], 8'hFF);
        $display("mid-count period write: toggle on next tick");

        do_reset();
        wr(8'h02, 8'h0F); wr(8'h03, 8'h02); wr(8'hF0, 8'h01);
        run(1);  check("noise_seed_bit0", LEVEL[7:0], 8'hFF);
        run(15); check("noise_seed_hold", LEVEL[7:0], 8'hFF);
        run(1);  check("noise_first_shift", LEVEL[7:0], 8'h00);
        $display("noise-only voice observes reset LFSR");

        do_reset();
        wr(8'h00, 8'd4); wr(8'h02, 8'h0F); wr(8'h03, 8'h01);
        run(40); check("midnote_before_reset", LEVEL[7:0], 8'hFF);
        wr(8'hF3, 8'h00);
        RESET = 1'b1;
        step(1'b1);
        RESET = 1'b0;
        check("midnote_reset_level", LEVEL, '0);
        check("midnote_reset_mix", MIX, '0);
        wr(8'h06, 8'h10);
        run(20); check("midnote_no_restart", LEVEL[15:8], 8'h00);
        $display("reset mid-note clears state and pending restart");

        for (int trial = 0; trial < 8; trial++) begin
            do_reset();
            for (int c = 0; c < CH; c++) begin
                cfg_per[c] = $urandom_range(0, 6);
                cfg_vol[c] = $urandom_range(0, 31);
                cfg_ctl[c] = $urandom_range(0, 3);
                wr(8'(4*c),     8'(cfg_per[c]));
                wr(8'(4*c + 1), 8'h00);
                wr(8'(4*c + 2), 8'(cfg_vol[c]));
                wr(8'(4*c + 3), 8'(cfg_ctl[c]));
            end
            cfg_np    = $urandom_range(0, 3);
            cfg_ep    = $urandom_range(0, 2);
            cfg_shape = $urandom_range(0, 15);
            wr(8'hF0, 8'(cfg_np));
            wr(8'hF1, 8'(cfg_ep));
            wr(8'hF2, 8'h00);
            wr(8'hF3, 8'(cfg_shape));
            k = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                if ($urandom_range(0, 3) != 0) begin
                    step(1'b1);
                    k++;
                end else begin
                    step(1'b0);
                end
                exp_mix = 0;
                for (int c = 0; c < CH; c++) begin
                    lv = exp_level(c, k);
                    exp_lv[8*c +: 8] = 8'(lv);
                    exp_mix += lv;
                end
                check($sformatf("rand_t%0d_k%0d_level", trial, k), LEVEL, exp_lv);
                check($sformatf("rand_t%0d_k%0d_mix", trial, k), MIX, 32'(exp_mix));
            end
            $display("random trial %0d: shape=%0h ep=%0d np=%0d per=%0d/%0d/%0d ce=%0d",
                     trial, cfg_shape, cfg_ep, cfg_np, cfg_per[0], cfg_per[1], cfg_per[2], k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psg_multi.md
Name: psg_multi

Overview:
Parametrised programmable sound generator, successor to the 3-voice PSG. Provides CHANNELS square-wave tone voices, one shared 17-bit noise LFSR and one shared 16-shape envelope. Each voice has an 8-bit log-scaled output, and all voices are summed into a saturation-free mix bus. It sits on the CPU I/O bus behind the existing sound glue and feeds the audio mixer directly.

Parameters:
CHANNELS, 3, number of tone voices; legal range 1..60.
TONE_W, 12, tone period width in bits; legal range 9..16.
PRESCALE, 8, number of CE ticks per tone/envelope tick; legal range 2..16.
MIX_W, 8+$clog2(CHANNELS+1), width of MIX; derived, must not be overridden.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous reset, active-high; applies to every register and state
CE  in  1  PSG clock enable; all audio state advances only on CLK edges where CE=1
WE  in  1  register write strobe, one CLK wide, independent of CE
ADDR  in  8  register address
DI  in  8  write data
DO  out  8  read data, combinational from ADDR
LEVEL  out  8*CHANNELS  per-voice level; voice c occupies bits [8c+7:8c]
MIX  out  MIX_W  sum of all LEVEL fields

Behaviour:
- Register map, per voice c at base 4c:
  - +0: tone period low byte.
  - +1: tone period high bits [TONE_W-9:0].
  - +2: volume [4:0]; bit4=1 selects the envelope level.
  - +3: control; bit0=tone enable, bit1=noise enable (active high).
- Global registers:
  - 0xF0: noise period [4:0].
  - 0xF1/0xF2: envelope period lo/hi.
  - 0xF3: envelope shape [3:0] = Cont, Att, Alt, Hold.
- Unimplemented bits read 0; unmapped addresses read 0x00 and ignore writes.
- Reset values: all registers 0; LFSR=17'h00001; tone outputs 0; envelope level 0 and held; LEVEL=0; MIX=0.
- Prescaler: counts CE ticks and asserts tick on every PRESCALE-th CE. Noise advances on every second tick.
- Tone voice:
  - Counter increments per tick.
  - When cnt >= period-1: cnt<=0 and the square output toggles.
  - Period 0: output forced 0 and counter held at 0.
  - Period written mid-count is compared immediately; if cnt already >= new period-1, the output toggles on the next tick.
- Noise:
  - Counter compares against the noise period in the same way as a tone voice.
  - On expiry: LFSR shifts right; new bit16 = bit0 ^ bit3; noise output = bit0.
  - Period 0: output 0.
- Gate per voice: (~tone_en | tone_out) & (~noise_en | noise_out). Both enables 0 gives a constant 1 (DC volume), matching legacy behaviour.
- Envelope:
  - Step counter as for tone; period 0 is treated as 1.
  - First ramp is 32 steps: 31→0 if Att=0, 0→31 if Att=1.
  - End of ramp, Cont=0: hold at 0.
  - End of ramp, Cont=1, Hold=1: hold at the final value, inverted if Alt=1.
  - End of ramp, Cont=1, Hold=0, Alt=1: reverse direction.
  - End of ramp, Cont=1, Hold=0, Alt=0: restart the same ramp.
- Envelope restart: a write to 0xF3 restarts the envelope at the next CE edge. Level is loaded to 31 or 0, the step counter is cleared and hold is released. The restart has priority over a step falling on the same CE.
- Level:
  - 5-bit amplitude = gate ? (vol[4] ? env : {vol[3:0],vol[3]}) : 0.
  - The amplitude maps through the 32-entry YM log table (0x00 … 0xFF) to 8 bits.
  - LEVEL and MIX are registered and update on the CLK edge with CE=1, one CE after the underlying state changes.
- MIX is the unsigned zero-extended sum of all LEVEL fields, computed every CE. Overflow is impossible by construction of MIX_W.
- Write arbitration:
  - A write with RESET=1 is ignored.
  - A write on a CE edge takes effect for compare on the next CE.
  - Multiple writes between CEs: the last write wins, and a single envelope restart is issued.
- Reset mid-note: all state clears on the same edge, LEVEL=0 from the next cycle, and no partial restart is pending afterwards.

Optional Feature:
PSG_STEREO_EN:
- Defined:
  - Control bit2 = pan-left enable and bit3 = pan-right enable (reset value 0).
  - Adds outputs MIX_L and MIX_R (MIX_W each); each sums only the voices panned to that side.
  - MIX is unchanged.
  - Control bits [3:2] read back.
- Undefined: control bits [3:2] read 0, no stereo ports exist, and MIX alone is produced.

Test Plan:
- Reset: after RESET, all DO reads return 0x00, LEVEL=0, MIX=0, and the LFSR state = 0x00001 via noise-only voice observation.
- Tone rate: PRESCALE=8, voice0 period=4, vol=0x0F, tone_en=1, CE=1 every CLK → LEVEL[7:0] toggles 0x00↔0xFF every 32 CLK.
- Envelope shape 0xE: period 1 → voice1 env-mode level ramps up 31 steps then down, a full triangle every 64 ticks (512 CE). Rewriting 0xF3 mid-ramp restarts at level 0 on the next CE.
- Envelope shape 0xB: ramps 31→0, then holds at 31 (table 0xFF) indefinitely.
- Mix: CHANNELS=3, all voices DC at vol 0x0F (enables 0) → MIX=0x2FD. With PSG_STEREO_EN and voice2 pan-left only: MIX_L=0xFF, MIX_R=0.
- Zero periods and mid-count writes: tone period 0 → gate 0 and LEVEL 0 with tone_en=1. With cnt=10, writing period 5 → output toggles on the next tick.
